// File: rtl/tube_host_master.sv
// rtl/tube_host_master.sv - host-side bus master generating phi2 cycles for a tube chip
//
// Turns single host register accesses into one full h_phi2 cycle on a
// 6502-style bus and sequences tube resets.
//
// Ports:
//   clock, reset_b          sole clock, asynchronous active-low reset
//   req_valid/req_ready     host access handshake; req_rnw/req_addr/req_wdata payload
//   host_rst_req            single-clock pulse asking for a tube reset
//   rsp_valid/rsp_rdata     one-clock completion pulse with read data
//   irq                     synchronised, inverted h_irq_b
//   h_phi2                  generated bus clock (low PHI2_LOW, high PHI2_HIGH clocks)
//   h_addr/h_cs_b/h_rdnw    bus address, chip select (active low), read/not-write
//   h_data_out/h_data_oe    write data and its output enable
//   h_data_in               bus data from the tube
//   h_rst_b                 tube reset, active low
//   h_irq_b                 tube interrupt, active low, asynchronous

module tube_host_master #(
    parameter int PHI2_LOW   = 12,
    parameter int PHI2_HIGH  = 12,
    parameter int RST_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       host_rst_req,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       irq,
    output logic       h_phi2,
    output logic [2:0] h_addr,
    output logic       h_cs_b,
    output logic       h_rdnw,
    output logic [7:0] h_data_out,
    output logic       h_data_oe,
    input  logic [7:0] h_data_in,
    output logic       h_rst_b,
    input  logic       h_irq_b
);

    localparam int         P       = PHI2_LOW + PHI2_HIGH;
    localparam logic [7:0] C_LAST  = 8'(P - 1);
    localparam logic [7:0] C_LOW   = 8'(PHI2_LOW);
    localparam logic [7:0] C_RLAST = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACTIVE,
        S_RESET
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic       w_enter_rst;

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic       w_wrap;
    logic       w_accept;

    logic       r_phi2;
    logic [2:0] r_h_addr;
    logic       r_h_cs_b;
    logic       r_h_rdnw;
    logic       r_h_oe;
    logic       r_h_rst_b;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;

    logic       r_req_rnw;
    logic [2:0] r_req_addr;
    logic [7:0] r_req_wdata;

    logic       r_rst_pend;
    logic [7:0] r_rcyc;
    logic       r_irq_s1;
    logic       r_irq_s2;

    // w_wrap marks the clock whose edge brings the counter back to 0;
    // every bus-cycle boundary decision is taken on that edge.
    assign w_wrap   = (r_cnt == C_LAST);
    assign w_cnt_nx = w_wrap ? 8'd0 : r_cnt + 8'd1;

    // A queued tube reset also blocks new requests, so nothing is accepted
    // only to be thrown away at the next boundary.
    assign req_ready = (r_state == S_IDLE) && r_h_rst_b && !host_rst_req && !r_rst_pend;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_enter_rst = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wrap && r_rst_pend) begin
                    w_state_nx  = S_RESET;
                    w_enter_rst = 1'b1;
                end else if (w_accept) begin
                    w_state_nx = S_PEND;
                end
            end
            S_PEND: begin
                if (w_wrap) begin
                    if (r_rst_pend) begin
                        w_state_nx  = S_RESET;
                        w_enter_rst = 1'b1;
                    end else begin
                        w_state_nx = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_wrap) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RESET: begin
                if (w_wrap && (r_rcyc == C_RLAST)) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt       <= 8'd0;
            r_phi2      <= 1'b0;
            r_h_addr    <= 3'd0;
            r_h_cs_b    <= 1'b1;
            r_h_rdnw    <= 1'b1;
            r_h_oe      <= 1'b0;
            r_h_rst_b   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_req_rnw   <= 1'b1;
            r_req_addr  <= 3'd0;
            r_req_wdata <= 8'd0;
            r_rst_pend  <= 1'b0;
            r_rcyc      <= 8'd0;
        end else begin
            r_cnt  <= w_cnt_nx;
            // Registered from the next count so h_phi2 lines up with the counter value.
            r_phi2 <= (w_cnt_nx >= C_LOW);

            if (w_accept) begin
                r_req_rnw   <= req_rnw;
                r_req_addr  <= req_addr;
                r_req_wdata <= req_wdata;
            end

            r_h_cs_b <= (w_state_nx != S_ACTIVE);
            if ((r_state == S_PEND) && (w_state_nx == S_ACTIVE)) begin
                r_h_addr <= r_req_addr;
                r_h_rdnw <= r_req_rnw;
            end else if (w_state_nx != S_ACTIVE) begin
                r_h_rdnw <= 1'b1;
            end

            // Drive data only during the high half of the access cycle.
            r_h_oe <= (w_state_nx == S_ACTIVE) && !r_req_rnw && (w_cnt_nx >= C_LOW);

            r_rsp_valid <= (r_state == S_ACTIVE) && w_wrap;
            if ((r_state == S_ACTIVE) && w_wrap) begin
                r_rsp_rdata <= r_req_rnw ? h_data_in : 8'h00;
            end

            if (w_enter_rst) begin
                r_rst_pend <= 1'b0;
            end else if (host_rst_req) begin
                r_rst_pend <= 1'b1;
            end

            if (w_enter_rst) begin
                r_rcyc <= 8'd0;
            end else if ((r_state == S_RESET) && w_wrap) begin
                r_rcyc <= r_rcyc + 8'd1;
            end

            r_h_rst_b <= (w_state_nx != S_RESET);
        end
    end

    // Flops reset to the deasserted level so irq reads 0 during reset.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_irq_s1 <= 1'b1;
            r_irq_s2 <= 1'b1;
        end else begin
            r_irq_s1 <= h_irq_b;
            r_irq_s2 <= r_irq_s1;
        end
    end

    assign irq        = ~r_irq_s2;
    assign h_phi2     = r_phi2;
    assign h_addr     = r_h_addr;
    assign h_cs_b     = r_h_cs_b;
    assign h_rdnw     = r_h_rdnw;
    assign h_data_out = r_req_wdata;
    assign h_data_oe  = r_h_oe;
    assign h_rst_b    = r_h_rst_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_tube_host_master.sv
// tb/tb_tube_host_master.sv - randomized self-checking bench for tube_host_master

module tb_tube_host_master;

    localparam int P   = 24;
    localparam int LOW = 12;
    localparam int RST = 4;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       host_rst_req;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       irq;
    logic       h_phi2;
    logic [2:0] h_addr;
    logic       h_cs_b;
    logic       h_rdnw;
    logic [7:0] h_data_out;
    logic       h_data_oe;
    logic [7:0] h_data_in;
    logic       h_rst_b;
    logic       h_irq_b;

    tube_host_master #(
        .PHI2_LOW  (LOW),
        .PHI2_HIGH (P - LOW),
        .RST_CYCLES(RST)
    ) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rnw     (req_rnw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .host_rst_req(host_rst_req),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .irq         (irq),
        .h_phi2      (h_phi2),
        .h_addr      (h_addr),
        .h_cs_b      (h_cs_b),
        .h_rdnw      (h_rdnw),
        .h_data_out  (h_data_out),
        .h_data_oe   (h_data_oe),
        .h_data_in   (h_data_in),
        .h_rst_b     (h_rst_b),
        .h_irq_b     (h_irq_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       rnw;
        logic [2:0] addr;
        logic [7:0] data;
    } req_t;

    req_t req_q[$];

    // Reference timeline: k = clocks since reset_b release. Accesses and
    // resets are described as clock windows derived from the phi2 period.
    int         k;
    int         win_w;
    logic       m_rnw;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    int         rst_req_k;
    int         rst_from;
    int         rst_to;
    logic [2:0] last_addr;
    logic [7:0] rd_hold;
    logic [7:0] rd_pend;
    logic       irq_val;
    logic       irq_prev;
    int         irq_chg;
    bit         arm_rst_act;
    bit         arm_rst_pend;
    bit         arm_areset;
    bit         din_fix;

    task automatic model_init();
        k         = 0;
        win_w     = -1;
        rst_req_k = -1;
        rst_from  = 0;
        rst_to    = RST * P;
        last_addr = 3'd0;
        rd_hold   = 8'd0;
        rd_pend   = 8'd0;
        irq_val   = 1'b1;
        irq_prev  = 1'b1;
        irq_chg   = -10;
        req_q.delete();
    endtask

    task automatic check_outputs();
        bit in_win;
        bit hi;
        in_win = (win_w >= 0) && (k >= win_w) && (k < win_w + P);
        hi     = ((k % P) >= LOW);
        if (win_w >= 0 && k == win_w) last_addr = m_addr;
        if (win_w >= 0 && k == win_w + P) rd_hold = rd_pend;
        check_eq("h_phi2", h_phi2, hi);
        check_eq("h_cs_b", h_cs_b, !in_win);
        check_eq("h_rdnw", h_rdnw, in_win ? m_rnw : 1'b1);
        check_eq("h_addr", h_addr, last_addr);
        check_eq("h_data_oe", h_data_oe, in_win && !m_rnw && hi);
        if (in_win && !m_rnw && hi) check_eq("h_data_out", h_data_out, m_data);
        check_eq("rsp_valid", rsp_valid, (win_w >= 0) && (k == win_w + P));
        check_eq("rsp_rdata", rsp_rdata, rd_hold);
        check_eq("h_rst_b", h_rst_b, !(k >= rst_from && k < rst_to));
        check_eq("irq", irq, (k >= irq_chg + 2) ? !irq_val : !irq_prev);
        if (win_w >= 0 && k == win_w + P) win_w = -1;
    endtask

    task automatic drive_inputs(input bit rnd);
        req_t r;
        bit   resetting;
        resetting    = (rst_req_k < k) && (k < rst_to);
        host_rst_req = 1'b0;
        h_data_in    = din_fix ? 8'hA5 : 8'($urandom);
        if (rnd && req_q.size() == 0 && $urandom_range(0, 5) == 0) begin
            r.rnw  = 1'($urandom);
            r.addr = 3'($urandom);
            r.data = 8'($urandom);
            req_q.push_back(r);
        end
        if (req_q.size() > 0) begin
            req_valid = 1'b1;
            req_rnw   = req_q[0].rnw;
            req_addr  = req_q[0].addr;
            req_wdata = req_q[0].data;
        end else begin
            req_valid = 1'b0;
            req_rnw   = 1'($urandom);
            req_addr  = 3'($urandom);
            req_wdata = 8'($urandom);
        end
        if (arm_rst_act && win_w >= 0 && k >= win_w && k <= win_w + P - 3) begin
            host_rst_req = 1'b1;
            arm_rst_act  = 1'b0;
        end else if (arm_rst_pend && win_w >= 0 && k + 2 <= win_w) begin
            host_rst_req = 1'b1;
            arm_rst_pend = 1'b0;
        end else if (rnd && !resetting && $urandom_range(0, 1499) == 0) begin
            host_rst_req = 1'b1;
        end
        if (rnd && k >= irq_chg + 3 && $urandom_range(0, 39) == 0) begin
            irq_prev = irq_val;
            irq_val  = !irq_val;
            irq_chg  = k;
            h_irq_b  = irq_val;
        end
    endtask

    task automatic post_drive();
        bit exp_ready;
        int e;
        exp_ready = !((rst_req_k < k) && (k < rst_to)) && !host_rst_req
                    && !((win_w >= 0) && (k < win_w + P));
        check_eq("req_ready", req_ready, exp_ready);
        if (req_valid && exp_ready) begin
            m_rnw  = req_q[0].rnw;
            m_addr = req_q[0].addr;
            m_data = req_q[0].data;
            win_w  = ((k + 1 + P - 1) / P) * P;
            void'(req_q.pop_front());
        end
        if (host_rst_req) begin
            e = ((k + 2 + P - 1) / P) * P;
            if (win_w >= 0 && win_w >= e) win_w = -1;
            else if (win_w >= 0 && win_w + P == e) e = e + P;
            rst_req_k = k;
            rst_from  = e;
            rst_to    = e + RST * P;
        end
        if (win_w >= 0 && k == win_w + P - 1) rd_pend = m_rnw ? h_data_in : 8'h00;
    endtask

    task automatic check_reset_state();
        check_eq("rst h_phi2", h_phi2, 1'b0);
        check_eq("rst h_cs_b", h_cs_b, 1'b1);
        check_eq("rst h_rdnw", h_rdnw, 1'b1);
        check_eq("rst h_addr", h_addr, 3'd0);
        check_eq("rst h_data_oe", h_data_oe, 1'b0);
        check_eq("rst rsp_valid", rsp_valid, 1'b0);
        check_eq("rst rsp_rdata", rsp_rdata, 8'd0);
        check_eq("rst req_ready", req_ready, 1'b0);
        check_eq("rst irq", irq, 1'b0);
        check_eq("rst h_rst_b", h_rst_b, 1'b0);
    endtask

    task automatic do_areset();
        reset_b      = 1'b0;
        req_valid    = 1'b0;
        host_rst_req = 1'b0;
        h_irq_b      = 1'b1;
        #1;
        check_reset_state();
        @(negedge clock);
        check_eq("areset rsp_valid", rsp_valid, 1'b0);
        @(negedge clock);
        reset_b    = 1'b1;
        arm_areset = 1'b0;
        model_init();
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            check_outputs();
            if (arm_areset && win_w >= 0 && k == win_w + 5) begin
                do_areset();
                continue;
            end
            drive_inputs(rnd);
            #1;
            post_drive();
            @(negedge clock);
            k++;
        end
    endtask

    task automatic push_req(input logic rnw, input logic [2:0] addr, input logic [7:0] data);
        req_t r;
        r.rnw  = rnw;
        r.addr = addr;
        r.data = data;
        req_q.push_back(r);
    endtask

    initial begin
        reset_b      = 1'b0;
        req_valid    = 1'b0;
        req_rnw      = 1'b0;
        req_addr     = 3'd0;
        req_wdata    = 8'd0;
        host_rst_req = 1'b0;
        h_data_in    = 8'd0;
        h_irq_b      = 1'b1;
        arm_rst_act  = 1'b0;
        arm_rst_pend = 1'b0;
        arm_areset   = 1'b0;
        din_fix      = 1'b0;
        model_init();
        repeat (3) @(negedge clock);
        check_reset_state();
        reset_b = 1'b1;
        model_init();

        run_cycles(110, 1'b0);

        push_req(1'b0, 3'd1, 8'h5A);
        run_cycles(100, 1'b0);

        din_fix = 1'b1;
        push_req(1'b1, 3'd0, 8'h00);
        run_cycles(100, 1'b0);
        din_fix = 1'b0;

        push_req(1'b0, 3'd6, 8'hC3);
        push_req(1'b1, 3'd2, 8'h00);
        run_cycles(150, 1'b0);

        arm_rst_act = 1'b1;
        push_req(1'b0, 3'd3, 8'h96);
        run_cycles(250, 1'b0);

        arm_rst_pend = 1'b1;
        push_req(1'b1, 3'd7, 8'h00);
        run_cycles(250, 1'b0);

        run_cycles(3000, 1'b1);

        arm_areset = 1'b1;
        push_req(1'b0, 3'd5, 8'h3C);
        run_cycles(100, 1'b0);
        run_cycles(200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tube_host_master.md
TUBE_HOST_MASTER -- requirements
Module: tube_host_master

Interface
REQ-001 The module SHALL have parameter PHI2_LOW, default 12, meaning clocks per h_phi2 low phase (range 2..128).
REQ-002 The module SHALL have parameter PHI2_HIGH, default 12, meaning clocks per h_phi2 high phase (range 2..128); P = PHI2_LOW+PHI2_HIGH.
REQ-003 The module SHALL have parameter RST_CYCLES, default 4, meaning h_phi2 cycles that h_rst_b is held low.
REQ-004 The module SHALL use one clock and an asynchronous active-low reset, with these ports:
 clock  in  1  sole clock, all state on rising edge
 reset_b  in  1  asynchronous active-low reset
 req_valid  in  1  host access request
 req_ready  out  1  request accepted when req_valid && req_ready
 req_rnw  in  1  1 = read, 0 = write
 req_addr  in  3  tube register address
 req_wdata  in  8  write data
 host_rst_req  in  1  single-clock pulse requesting a tube reset
 rsp_valid  out  1  one-clock pulse: access complete
 rsp_rdata  out  8  read data, valid with rsp_valid
 irq  out  1  synchronised, inverted h_irq_b
 h_phi2  out  1  generated 6502-style bus clock
 h_addr  out  3  bus address
 h_cs_b  out  1  tube chip select, active low
 h_rdnw  out  1  bus read/not-write
 h_data_out  out  8  write data to bus
 h_data_oe  out  1  1 = drive h_data_out onto bus
 h_data_in  in  8  bus data from the tube
 h_rst_b  out  1  tube reset, active low
 h_irq_b  in  1  tube interrupt, active low, asynchronous

Function
REQ-005 An 8-bit phase counter SHALL count 0..P-1 and then wrap to 0; it runs continuously once reset_b is high.
REQ-006 h_phi2 SHALL be registered: 0 while the counter is 0..PHI2_LOW-1, and 1 while it is PHI2_LOW..P-1.
REQ-007 The state machine SHALL have states IDLE, PEND, ACTIVE and RESET.
REQ-008 req_ready SHALL be 1 only when state=IDLE, h_rst_b=1 and host_rst_req=0.
REQ-009 On acceptance, the module SHALL latch req_rnw, req_addr and req_wdata, and go IDLE->PEND.
REQ-010 PEND->ACTIVE SHALL occur when the counter wraps to 0; on that clock h_cs_b=0 and h_addr/h_rdnw take the latched values.
REQ-011 In ACTIVE, h_cs_b, h_addr and h_rdnw SHALL be stable for exactly P clocks, one full h_phi2 cycle.
REQ-012 For writes, h_data_oe SHALL be 1 exactly while h_phi2=1 within ACTIVE, with h_data_out equal to the latched data.
REQ-013 For reads, h_data_oe SHALL stay 0.
REQ-014 At counter = P-1 in ACTIVE, h_data_in SHALL be sampled: rsp_rdata gets h_data_in on a read and 8'h00 on a write.
REQ-015 rsp_valid SHALL pulse for one clock coincident with the counter wrap to 0; on that clock the state returns to IDLE, h_cs_b=1 and h_rdnw=1.
REQ-016 h_addr SHALL hold its last value when idle.
REQ-017 A minimum of one idle h_phi2 cycle SHALL separate back-to-back accesses.
REQ-018 host_rst_req SHALL set a pending flag, which is cleared when RESET is entered.
REQ-019 RESET SHALL be entered at the next counter wrap while the state is IDLE or PEND; a pending request is dropped with no rsp_valid.
REQ-020 If host_rst_req arrives in ACTIVE, the access SHALL complete with rsp_valid, and RESET is entered at the following wrap.
REQ-021 In RESET, h_rst_b SHALL be 0 for exactly RST_CYCLES*P clocks, aligned to wraps, then the state goes to IDLE.
REQ-022 h_irq_b SHALL pass through a 2-flop synchroniser, and irq = NOT of the second flop.

Reset
REQ-023 While reset_b=0, outputs SHALL be: counter 0, h_phi2 0, h_cs_b 1, h_rdnw 1, h_addr 0, h_data_out 0, h_data_oe 0, rsp_valid 0, rsp_rdata 0, req_ready 0, irq 0, h_rst_b 0.
REQ-024 Reset SHALL put the state in RESET, so a power-on tube reset of RST_CYCLES*P clocks follows reset_b release.
REQ-025 An asynchronous reset SHALL abort any access in progress with no rsp_valid and drop any pending request.

Verification (defaults, P=24)
REQ-026 Release reset_b -> h_rst_b rises on clock 96, req_ready=1 from that clock, and h_phi2 has period 24 with a 12/12 duty.
REQ-027 Write addr 1, data 0x5A -> h_cs_b low for 24 clocks starting at a wrap; h_data_oe=1 for 12 clocks with 0x5A; one rsp_valid pulse with rsp_rdata 0x00.
REQ-028 Read addr 0 with h_data_in=0xA5 at counter 23 -> rsp_rdata=0xA5 with rsp_valid, h_data_oe never asserted.
REQ-029 Two requests presented back-to-back -> two ACTIVE windows separated by at least 24 clocks with h_cs_b=1; two rsp_valid pulses in order.
REQ-030 host_rst_req during ACTIVE -> rsp_valid still issued, then h_rst_b low for 96 clocks, with req_ready=0 throughout.
REQ-031 h_irq_b low -> irq=1 within 2 clocks; reset_b pulsed mid-access -> no rsp_valid, h_cs_b=1 immediately.
